// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus source arbiter and future one-hot decoders.
package bus_arb_pkg;

  localparam int BUS_W   = 16;
  localparam int MAX_SRC = 16;

  typedef logic [BUS_W-1:0] bus_word_t;

  // True when exactly one bit of v is set; callers zero-extend narrower vectors.
  function automatic logic is_onehot(input logic [MAX_SRC-1:0] v);
    return (v != '0) && ((v & (v - MAX_SRC'(1))) == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from rr_ptr upward with wrap, owns the rr_ptr register.
module rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] eligible,
  input  logic               update,
  output logic [SRC_W-1:0]   winner,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   rr_ptr
);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W:0]   scan_idx;
  logic             found;

  // First eligible index at or after rr_ptr, wrapping inside 0..NUM_SRC-1.
  always_comb begin
    winner   = '0;
    grant    = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(off);
      if (scan_idx >= (SRC_W+1)'(NUM_SRC)) begin
        scan_idx = scan_idx - (SRC_W+1)'(NUM_SRC);
      end
      if (!found && eligible[scan_idx[SRC_W-1:0]]) begin
        found                        = 1'b1;
        winner                       = scan_idx[SRC_W-1:0];
        grant[scan_idx[SRC_W-1:0]]   = 1'b1;
      end
    end
  end

  // Pointer moves past the winner; explicit wrap keeps it below NUM_SRC for any size.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (update && found) begin
      rr_ptr_d = (winner == SRC_W'(NUM_SRC-1)) ? '0 : winner + SRC_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/bus_arb_mux.sv
// Arbitrated source mux: round-robin or forced selection onto one registered
// output word with a valid/ready handshake and illegal-select flagging.
module bus_arb_mux
  import bus_arb_pkg::*;
#(
  parameter int WIDTH   = BUS_W,
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]         src_ack,
  input  logic                       force_en,
  input  logic [NUM_SRC-1:0]         force_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [SRC_W-1:0]           out_src,
  output logic                       sel_err
);

  logic [WIDTH-1:0]   src_word [NUM_SRC];
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   rr_ptr;
  logic               force_legal;
  logic               load;
  logic               grant_fire;
  logic               rr_update;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [SRC_W-1:0]   out_src_q,   out_src_d;
  logic               sel_err_q,   sel_err_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Eligibility masking and handshake; no acks are issued while reset is held.
  always_comb begin
    force_legal = is_onehot(MAX_SRC'(force_sel));
    eligible    = src_req;
    if (force_en) begin
      eligible = force_legal ? (src_req & force_sel) : '0;
    end
    load       = !out_valid_q || out_ready;
    grant_fire = load && rst_n && (eligible != '0);
    rr_update  = grant_fire && !force_en;
    src_ack    = grant_fire ? grant : '0;
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .update   (rr_update),
    .winner   (winner),
    .grant    (grant),
    .rr_ptr   (rr_ptr)
  );

  // Output register next state: load on grant, drain valid on empty load, hold on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = grant_fire;
      if (grant_fire) begin
        out_data_d = src_word[winner];
        out_src_d  = winner;
      end
    end
    sel_err_d = force_en && !force_legal;
  end

  // Output and error flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: a 4-source instance for the main scenarios and
// a 3-source instance for wrap-around and asynchronous reset mid-stream.
module tb_bus_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-source instance
  logic        a_rst_n;
  logic [3:0]  a_src_req;
  logic [63:0] a_src_data;
  logic [3:0]  a_src_ack;
  logic        a_force_en;
  logic [3:0]  a_force_sel;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_src;
  logic        a_sel_err;

  // 3-source instance
  logic        b_rst_n;
  logic [2:0]  b_src_req;
  logic [47:0] b_src_data;
  logic [2:0]  b_src_ack;
  logic        b_force_en;
  logic [2:0]  b_force_sel;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_src;
  logic        b_sel_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  bus_arb_mux #(.WIDTH(16), .NUM_SRC(4)) dut_a (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .src_req   (a_src_req),
    .src_data  (a_src_data),
    .src_ack   (a_src_ack),
    .force_en  (a_force_en),
    .force_sel (a_force_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_src   (a_out_src),
    .sel_err   (a_sel_err)
  );

  bus_arb_mux #(.WIDTH(16), .NUM_SRC(3)) dut_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .src_req   (b_src_req),
    .src_data  (b_src_data),
    .src_ack   (b_src_ack),
    .force_en  (b_force_en),
    .force_sel (b_force_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_src   (b_out_src),
    .sel_err   (b_sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int rr_seq [4] = '{3, 0, 3, 0};

  initial begin
    a_rst_n     = 1'b0;
    a_src_req   = 4'b1111;
    a_src_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    a_force_en  = 1'b0;
    a_force_sel = 4'b0000;
    a_out_ready = 1'b1;
    b_rst_n     = 1'b0;
    b_src_req   = 3'b000;
    b_src_data  = {16'hC002, 16'hC001, 16'hC000};
    b_force_en  = 1'b0;
    b_force_sel = 3'b000;
    b_out_ready = 1'b1;

    // 1. Reset state, then round-robin over all four requesters
    @(negedge clk); #1;
    chk("rst_ack",   32'(a_src_ack),   32'h0);
    chk("rst_valid", 32'(a_out_valid), 32'h0);
    chk("rst_data",  32'(a_out_data),  32'h0);
    chk("rst_src",   32'(a_out_src),   32'h0);
    chk("rst_err",   32'(a_sel_err),   32'h0);
    @(negedge clk);
    a_rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rr4_ack", 32'(a_src_ack), 32'(4'b0001 << (i % 4)));
      if (i > 0) begin
        chk("rr4_src",   32'(a_out_src),   32'((i - 1) % 4));
        chk("rr4_valid", 32'(a_out_valid), 32'h1);
        chk("rr4_data",  32'(a_out_data),  32'(16'hA000 + 16'((i - 1) % 4)));
      end
      @(negedge clk); #1;
    end
    chk("rr4_last_src", 32'(a_out_src), 32'h0);

    // 2. Backpressure: load BEEF, stall five cycles, then accept and re-ack
    a_src_req = 4'b0100;
    a_src_data[47:32] = 16'hBEEF;
    #1;
    chk("bp_ack_load", 32'(a_src_ack), 32'h4);
    @(negedge clk);
    a_out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall_ack",   32'(a_src_ack),   32'h0);
      chk("bp_stall_valid", 32'(a_out_valid), 32'h1);
      chk("bp_stall_data",  32'(a_out_data),  32'hBEEF);
      @(negedge clk); #1;
    end
    chk("bp_stall_src", 32'(a_out_src), 32'h2);
    a_out_ready = 1'b1;
    #1;
    chk("bp_accept_ack", 32'(a_src_ack), 32'h4);
    @(negedge clk);
    a_src_req = 4'b0000;
    #1;
    chk("bp_reload_valid", 32'(a_out_valid), 32'h1);
    chk("bp_idle_ack",     32'(a_src_ack),   32'h0);
    @(negedge clk); #1;
    chk("bp_drain_valid", 32'(a_out_valid), 32'h0);
    chk("bp_hold_data",   32'(a_out_data),  32'hBEEF);
    chk("bp_hold_src",    32'(a_out_src),   32'h2);

    // 3. Fairness between src0 and src3 starting from rr_ptr=3, then wrap scan
    a_src_req = 4'b1001;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fair_ack", 32'(a_src_ack), 32'(4'b0001 << rr_seq[k]));
      @(negedge clk); #1;
      chk("fair_src", 32'(a_out_src), 32'(rr_seq[k]));
    end
    a_src_req = 4'b0100;
    #1;
    chk("wrap_setup_ack", 32'(a_src_ack), 32'h4);
    @(negedge clk);
    a_src_req = 4'b0010;
    #1;
    chk("wrap_scan_ack", 32'(a_src_ack), 32'h2);
    @(negedge clk);

    // 4. Forced select of src1; rr_ptr (2) must survive the forced grants
    a_force_en  = 1'b1;
    a_force_sel = 4'b0010;
    a_src_req   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("force_ack", 32'(a_src_ack), 32'h2);
      @(negedge clk);
    end
    #1;
    chk("force_src", 32'(a_out_src), 32'h1);
    a_force_en = 1'b0;
    #1;
    chk("force_resume_ack", 32'(a_src_ack), 32'h4);
    @(negedge clk);

    // 5. Illegal selects: multi-hot and zero
    a_force_en  = 1'b1;
    a_force_sel = 4'b0110;
    #1;
    chk("ill_multi_ack", 32'(a_src_ack), 32'h0);
    @(negedge clk);
    a_force_en = 1'b0;
    a_src_req  = 4'b0000;
    #1;
    chk("ill_multi_err",   32'(a_sel_err),   32'h1);
    chk("ill_multi_valid", 32'(a_out_valid), 32'h0);
    @(negedge clk); #1;
    chk("ill_multi_clr", 32'(a_sel_err), 32'h0);
    a_force_en  = 1'b1;
    a_force_sel = 4'b0000;
    a_src_req   = 4'b1111;
    #1;
    chk("ill_zero_ack", 32'(a_src_ack), 32'h0);
    @(negedge clk);
    a_force_en = 1'b0;
    a_src_req  = 4'b0000;
    #1;
    chk("ill_zero_err", 32'(a_sel_err), 32'h1);
    @(negedge clk); #1;
    chk("ill_zero_clr", 32'(a_sel_err), 32'h0);

    // 6. Three sources: wrap after src2, async reset while holding a word
    @(negedge clk);
    b_src_req = 3'b111;
    b_rst_n   = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("n3_ack", 32'(b_src_ack), 32'(3'b001 << (k % 3)));
      @(negedge clk); #1;
      chk("n3_src", 32'(b_out_src), 32'(k % 3));
    end
    b_src_req = 3'b000;
    #1;
    chk("n3_pre_rst_valid", 32'(b_out_valid), 32'h1);
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("n3_rst_valid", 32'(b_out_valid), 32'h0);
    chk("n3_rst_data",  32'(b_out_data),  32'h0);
    chk("n3_rst_src",   32'(b_out_src),   32'h0);
    b_src_req = 3'b101;
    #1;
    chk("n3_rst_ack", 32'(b_src_ack), 32'h0);
    @(negedge clk);
    b_rst_n = 1'b1;
    #1;
    chk("n3_post_rst_ack", 32'(b_src_ack), 32'h1);
    @(negedge clk); #1;
    chk("n3_post_rst_src",   32'(b_out_src),   32'h0);
    chk("n3_post_rst_valid", 32'(b_out_valid), 32'h1);
    chk("n3_post_rst_data",  32'(b_out_data),  32'hC000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
